// File: rtl/usart_bus_ctrl_if.sv
// Byte-wide register bus plus host-side valid/ready stream for the USART bus controller.
interface usart_bus_ctrl_if;
  logic       i_start;
  logic [7:0] o_addr;
  logic [7:0] o_word;
  logic       o_we;
  logic [7:0] i_word;
  logic       i_tx_valid;
  logic [7:0] i_tx_data;
  logic       o_tx_ready;
  logic       o_rx_valid;
  logic [7:0] o_rx_data;
  logic       o_cfg_done;
  logic       o_busy;
  logic       o_tx_err;

  modport master (
    input  i_start, i_word, i_tx_valid, i_tx_data,
    output o_addr, o_word, o_we, o_tx_ready, o_rx_valid, o_rx_data, o_cfg_done, o_busy, o_tx_err
  );

  modport slave (
    output i_start, i_word, i_tx_valid, i_tx_data,
    input  o_addr, o_word, o_we, o_tx_ready, o_rx_valid, o_rx_data, o_cfg_done, o_busy, o_tx_err
  );
endinterface

// File: rtl/usart_bus_ctrl.sv
// USART bus master: programs baud/format/enables, then polls UCSRA to drain RX and stream TX.
module usart_bus_ctrl #(
  parameter logic [11:0] UBRR      = 12'd51,
  parameter logic [7:0]  UCSRC_VAL = 8'h86,
  parameter logic [7:0]  UCSRB_VAL = 8'h18,
  parameter logic [7:0]  UCSRA_VAL = 8'h00,
  parameter logic [15:0] TIMEOUT   = 16'd4095
) (
  input logic              i_fosk,
  input logic              i_rst_n,
  usart_bus_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    StIdle, StWUbrrh, StWUbrrl, StWUcsrc, StWUcsra, StWUcsrb, StPoll, StRxPop, StTxWr
  } state_e;

  localparam logic [7:0] AddrUdr   = 8'h00;
  localparam logic [7:0] AddrUcsra = 8'h01;
  localparam logic [7:0] AddrIdle  = 8'hFF;

  state_e      state_q;
  logic [7:0]  addr_q;
  logic [7:0]  word_q;
  logic        we_q;
  logic        rx_valid_q;
  logic [7:0]  rx_data_q;
  logic        cfg_done_q;
  logic        busy_q;
  logic        tx_err_q;
  logic        hold_full_q;
  logic [7:0]  hold_data_q;
  logic [15:0] cnt_q;
  logic        tx_ready;

  assign tx_ready = cfg_done_q && !hold_full_q && bus.i_tx_valid;

  always_ff @(posedge i_fosk) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      addr_q      <= AddrIdle;
      word_q      <= 8'h00;
      we_q        <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= 8'h00;
      cfg_done_q  <= 1'b0;
      busy_q      <= 1'b0;
      tx_err_q    <= 1'b0;
      hold_full_q <= 1'b0;
      hold_data_q <= 8'h00;
      cnt_q       <= 16'd0;
    end else begin
      rx_valid_q <= 1'b0;
      tx_err_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.i_start) begin
            state_q <= StWUbrrh;
            addr_q  <= 8'h03;
            word_q  <= {4'b0000, UBRR[11:8]};
            we_q    <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        StWUbrrh: begin
          state_q <= StWUbrrl;
          addr_q  <= 8'h04;
          word_q  <= UBRR[7:0];
        end
        StWUbrrl: begin
          // Same address as UBRRH; bit7 set steers the write to UCSRC.
          state_q <= StWUcsrc;
          addr_q  <= 8'h03;
          word_q  <= UCSRC_VAL | 8'h80;
        end
        StWUcsrc: begin
          state_q <= StWUcsra;
          addr_q  <= AddrUcsra;
          word_q  <= UCSRA_VAL & 8'h03;
        end
        StWUcsra: begin
          state_q <= StWUcsrb;
          addr_q  <= 8'h02;
          word_q  <= UCSRB_VAL;
        end
        StWUcsrb: begin
          state_q    <= StPoll;
          addr_q     <= AddrUcsra;
          word_q     <= 8'h00;
          we_q       <= 1'b0;
          busy_q     <= 1'b0;
          cfg_done_q <= 1'b1;
        end
        StPoll: begin
          if (hold_full_q && !bus.i_word[5]) begin
            if (cnt_q == TIMEOUT - 16'd1) begin
              hold_full_q <= 1'b0;
              cnt_q       <= 16'd0;
              tx_err_q    <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          // RX drains before TX so the receiver never overruns while TX is pending.
          if (bus.i_word[7]) begin
            state_q <= StRxPop;
            addr_q  <= AddrUdr;
            busy_q  <= 1'b1;
          end else if (hold_full_q && bus.i_word[5]) begin
            state_q <= StTxWr;
            addr_q  <= AddrUdr;
            word_q  <= hold_data_q;
            we_q    <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        StRxPop: begin
          rx_data_q  <= bus.i_word;
          rx_valid_q <= 1'b1;
          state_q    <= StPoll;
          addr_q     <= AddrUcsra;
          busy_q     <= 1'b0;
        end
        StTxWr: begin
          hold_full_q <= 1'b0;
          cnt_q       <= 16'd0;
          state_q     <= StPoll;
          addr_q      <= AddrUcsra;
          word_q      <= 8'h00;
          we_q        <= 1'b0;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          addr_q  <= AddrIdle;
          word_q  <= 8'h00;
          we_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
      if (tx_ready) begin
        hold_full_q <= 1'b1;
        hold_data_q <= bus.i_tx_data;
      end
    end
  end

  assign bus.o_addr     = addr_q;
  assign bus.o_word     = word_q;
  assign bus.o_we       = we_q;
  assign bus.o_tx_ready = tx_ready;
  assign bus.o_rx_valid = rx_valid_q;
  assign bus.o_rx_data  = rx_data_q;
  assign bus.o_cfg_done = cfg_done_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_tx_err   = tx_err_q;

endmodule

// File: tb/tb_usart_bus_ctrl.sv
// Bench for usart_bus_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_usart_bus_ctrl;
  localparam logic [11:0] UBRR      = 12'd51;
  localparam logic [7:0]  UCSRC_VAL = 8'h86;
  localparam logic [7:0]  UCSRB_VAL = 8'h18;
  localparam logic [7:0]  UCSRA_VAL = 8'h00;
  localparam int          TMO       = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  usart_bus_ctrl_if bus();
  logic [7:0] ucsra = 8'h00;
  logic [7:0] udr = 8'h00;

  // USART register stub: UCSRA at 01, UDR at 00, anything else reads a marker.
  assign bus.i_word = (bus.o_addr == 8'h01) ? ucsra : (bus.o_addr == 8'h00) ? udr : 8'hEE;

  usart_bus_ctrl #(
    .UBRR(UBRR), .UCSRC_VAL(UCSRC_VAL), .UCSRB_VAL(UCSRB_VAL), .UCSRA_VAL(UCSRA_VAL),
    .TIMEOUT(16'(TMO))
  ) dut (
    .i_fosk (clk),
    .i_rst_n(rst_n),
    .bus    (bus.master)
  );

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: config is a table walk; afterwards each cycle is a poll, a pop or a write.
  int         m_step = 0;   // 0 idle, 1..5 config write index, 6 running
  int         m_acc = 0;    // 0 poll, 1 pop, 2 write
  bit         m_full = 0;
  logic [7:0] m_hold = 0;
  int         m_cnt = 0;
  bit         m_rx_valid = 0;
  logic [7:0] m_rx_data = 0;
  bit         m_err = 0;
  bit         m_live = 0;
  logic [7:0] txq[$];

  function automatic logic [15:0] cfg_entry(input int s);
    case (s)
      1: return {8'h03, 4'h0, UBRR[11:8]};
      2: return {8'h04, UBRR[7:0]};
      3: return {8'h03, UCSRC_VAL | 8'h80};
      4: return {8'h01, UCSRA_VAL & 8'h03};
      default: return {8'h02, UCSRB_VAL};
    endcase
  endfunction

  always @(negedge clk) begin
    logic [7:0] e_addr, e_word;
    logic e_we, e_busy, e_cfg, e_ready, rxc, udre;
    logic [15:0] ce;
    e_ready = 1'b0;
    if (m_step == 0) begin
      e_addr = 8'hFF; e_word = 8'h00; e_we = 0; e_busy = 0; e_cfg = 0;
    end else if (m_step < 6) begin
      ce = cfg_entry(m_step);
      e_addr = ce[15:8]; e_word = ce[7:0]; e_we = 1; e_busy = 1; e_cfg = 0;
    end else begin
      e_cfg = 1;
      e_ready = !m_full && bus.i_tx_valid;
      if (m_acc == 0) begin
        e_addr = 8'h01; e_word = 8'h00; e_we = 0; e_busy = 0;
      end else if (m_acc == 1) begin
        e_addr = 8'h00; e_word = 8'h00; e_we = 0; e_busy = 1;
      end else begin
        e_addr = 8'h00; e_word = m_hold; e_we = 1; e_busy = 1;
      end
    end

    if (m_live) begin
      chk("cycle_outputs",
          32'({bus.o_addr, bus.o_word, bus.o_we, bus.o_tx_ready, bus.o_rx_valid, bus.o_rx_data,
               bus.o_cfg_done, bus.o_busy, bus.o_tx_err}),
          32'({e_addr, e_word, e_we, e_ready, m_rx_valid, m_rx_data, e_cfg, e_busy, m_err}));
      if (bus.o_addr == 8'h00 && bus.o_we === 1'b1) begin
        chk("tx_write_pending", 32'(txq.size() > 0), 32'd1);
        if (txq.size() > 0) chk("tx_write_order", 32'(bus.o_word), 32'(txq.pop_front()));
      end
      if (bus.o_tx_err === 1'b1 && txq.size() > 0) void'(txq.pop_front());
      if (bus.o_tx_ready === 1'b1) txq.push_back(bus.i_tx_data);
    end

    m_rx_valid = 0;
    m_err = 0;
    if (!rst_n) begin
      m_step = 0; m_acc = 0; m_full = 0; m_hold = 0; m_cnt = 0; m_rx_data = 0;
      m_live = 1;
      txq.delete();
    end else if (m_step == 0) begin
      if (bus.i_start) m_step = 1;
    end else if (m_step < 6) begin
      m_step++;
      m_acc = 0;
    end else begin
      if (m_acc == 1) begin
        m_rx_data = bus.i_word; m_rx_valid = 1; m_acc = 0;
      end else if (m_acc == 2) begin
        m_full = 0; m_cnt = 0; m_acc = 0;
      end else begin
        rxc = bus.i_word[7];
        udre = bus.i_word[5];
        m_acc = rxc ? 1 : (m_full && udre) ? 2 : 0;
        if (m_full && !udre) begin
          m_cnt++;
          if (m_cnt >= TMO) begin
            m_full = 0; m_cnt = 0; m_err = 1;
          end
        end
      end
      if (e_ready) begin
        m_full = 1; m_hold = bus.i_tx_data;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] exp_cfg[5];
    logic [7:0] v;
    int pct;
    exp_cfg[0] = 16'h0300; exp_cfg[1] = 16'h0433; exp_cfg[2] = 16'h0386;
    exp_cfg[3] = 16'h0100; exp_cfg[4] = 16'h0218;
    bus.i_start = 0; bus.i_tx_valid = 0; bus.i_tx_data = 0;
    repeat (3) step();
    @(negedge clk);
    chk("reset_state", 32'({bus.o_addr, bus.o_we, bus.o_cfg_done, bus.o_busy, bus.o_tx_err}),
        32'({8'hFF, 4'b0000}));

    // Config sequence with a TX byte already offered; UDRE set so it streams out at once.
    step();
    rst_n = 1; bus.i_start = 1; bus.i_tx_valid = 1; bus.i_tx_data = 8'hA5; ucsra = 8'h20;
    step();
    bus.i_start = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("cfg_write", 32'({bus.o_addr, bus.o_word, bus.o_we}), 32'({exp_cfg[i], 1'b1}));
      chk("cfg_ready_low", 32'({bus.o_tx_ready, bus.o_cfg_done}), 32'd0);
      step();
    end
    @(negedge clk);
    chk("first_poll", 32'({bus.o_addr, bus.o_we, bus.o_cfg_done, bus.o_tx_ready}),
        32'({8'h01, 3'b011}));
    step();
    bus.i_tx_valid = 0;
    step();
    @(negedge clk);
    chk("tx_write_a5", 32'({bus.o_addr, bus.o_word, bus.o_we}), 32'({16'h00A5, 1'b1}));
    step();

    // RXC and a pending TX byte together: pop first, write next.
    bus.i_tx_valid = 1; bus.i_tx_data = 8'h3C; ucsra = 8'hA0; udr = 8'h5A;
    @(negedge clk);
    chk("accept_3c", 32'(bus.o_tx_ready), 32'd1);
    step();
    bus.i_tx_valid = 0; ucsra = 8'h20;
    @(negedge clk);
    chk("rx_pop_first", 32'({bus.o_addr, bus.o_we, bus.o_busy}), 32'({8'h00, 2'b01}));
    step();
    @(negedge clk);
    chk("rx_data_5a", 32'({bus.o_rx_valid, bus.o_rx_data}), 32'({1'b1, 8'h5A}));
    step();
    @(negedge clk);
    chk("tx_write_3c", 32'({bus.o_addr, bus.o_word, bus.o_we}), 32'({16'h003C, 1'b1}));
    step();

    // Timeout: UDRE never rises, byte dropped after TMO polls.
    bus.i_tx_valid = 1; bus.i_tx_data = 8'h77; ucsra = 8'h00;
    step();
    bus.i_tx_valid = 0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      chk("timeout_no_err_yet", 32'({bus.o_tx_err, bus.o_we}), 32'd0);
      step();
    end
    bus.i_tx_valid = 1; bus.i_tx_data = 8'h99;
    @(negedge clk);
    chk("timeout_err", 32'({bus.o_tx_err, bus.o_tx_ready}), 32'b11);
    step();
    bus.i_tx_valid = 0; ucsra = 8'h20;
    @(negedge clk);
    chk("err_one_pulse", 32'(bus.o_tx_err), 32'd0);

    // Randomized traffic; some blocks starve UDRE to provoke timeouts.
    for (int blk = 0; blk < 60; blk++) begin
      pct = (blk % 3 == 0) ? 5 : 60;
      for (int c = 0; c < 50; c++) begin
        step();
        v = 8'($urandom);
        v[7] = ($urandom_range(0, 99) < 20);
        v[5] = ($urandom_range(0, 99) < pct);
        ucsra = v;
        udr = 8'($urandom);
        bus.i_tx_valid = 1'($urandom_range(0, 1));
        bus.i_tx_data = 8'($urandom);
        bus.i_start = ($urandom_range(0, 99) == 0);
      end
    end

    // Reset during the UCSRC write, then a full rerun with TX offered early.
    step();
    bus.i_start = 0; bus.i_tx_valid = 0; ucsra = 8'h00; rst_n = 0;
    step();
    rst_n = 1; bus.i_start = 1; bus.i_tx_valid = 1; bus.i_tx_data = 8'hC3;
    step();
    bus.i_start = 0;
    step();
    step();
    @(negedge clk);
    chk("in_ucsrc", 32'({bus.o_addr, bus.o_word, bus.o_we}), 32'({16'h0386, 1'b1}));
    rst_n = 0;
    step();
    @(negedge clk);
    chk("abort_reset", 32'({bus.o_addr, bus.o_we, bus.o_cfg_done, bus.o_tx_ready}),
        32'({8'hFF, 3'b000}));
    rst_n = 1; bus.i_start = 1;
    step();
    bus.i_start = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rerun_cfg", 32'({bus.o_addr, bus.o_word, bus.o_we, bus.o_tx_ready}),
          32'({exp_cfg[i], 2'b10}));
      step();
    end
    @(negedge clk);
    chk("ready_after_cfg", 32'({bus.o_cfg_done, bus.o_tx_ready}), 32'b11);
    step();
    bus.i_tx_valid = 0; ucsra = 8'h20;
    repeat (4) step();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end
endmodule
